// File: rtl/freeahb_ui_ahb_master.sv
// Single-transfer AHB 2.0 master behind the FreeAHB-style user interface.
// Issues one NONSEQ/SINGLE per request and re-issues on RETRY/SPLIT up to MAX_RETRY times.
module freeahb_ui_ahb_master #(
   parameter int MAX_RETRY = 8
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        freeahb_read,
   input  logic        freeahb_write,
   input  logic        freeahb_valid,
   input  logic [31:0] freeahb_addr,
   input  logic [2:0]  freeahb_size,
   input  logic [31:0] freeahb_wdata,
   input  logic [3:0]  freeahb_prot,
   input  logic        freeahb_lock,
   input  logic [31:0] freeahb_min_len,
   input  logic        freeahb_cont,
   output logic        freeahb_next,
   output logic        freeahb_ready,
   output logic [31:0] freeahb_rdata,
   output logic [31:0] freeahb_result_addr,
   output logic        freeahb_err,
   input  logic        hgrant,
   input  logic        hready,
   input  logic [1:0]  hresp,
   input  logic [31:0] hrdata,
   output logic        hbusreq,
   output logic        hlock,
   output logic [1:0]  htrans,
   output logic [31:0] haddr,
   output logic        hwrite,
   output logic [2:0]  hsize,
   output logic [2:0]  hburst,
   output logic [3:0]  hprot,
   output logic [31:0] hwdata
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_ADDR,
      S_DATA,
      S_RELEASE
   } state_t;

   localparam logic [1:0] TRANS_IDLE   = 2'b00;
   localparam logic [1:0] TRANS_NONSEQ = 2'b10;
   localparam logic [7:0] MAX_R        = 8'(MAX_RETRY);

   state_t      state;
   logic [31:0] addr_q;
   logic [2:0]  size_q;
   logic        write_q;
   logic [31:0] wdata_q;
   logic [3:0]  prot_q;
   logic        lock_q;
   logic        next_done;
   logic [7:0]  retry_cnt;

   logic unused_inputs;
   assign unused_inputs = &{1'b0, freeahb_valid, freeahb_min_len, freeahb_cont};

   assign hburst = 3'b000;

   // hresp[1] marks RETRY/SPLIT; next_done keeps a re-issued transfer from pulsing next twice.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state               <= S_IDLE;
         addr_q              <= '0;
         size_q              <= '0;
         write_q             <= 1'b0;
         wdata_q             <= '0;
         prot_q              <= '0;
         lock_q              <= 1'b0;
         next_done           <= 1'b0;
         retry_cnt           <= '0;
         freeahb_next        <= 1'b0;
         freeahb_ready       <= 1'b0;
         freeahb_rdata       <= '0;
         freeahb_result_addr <= '0;
         freeahb_err         <= 1'b0;
         hbusreq             <= 1'b0;
         hlock               <= 1'b0;
         htrans              <= TRANS_IDLE;
         haddr               <= '0;
         hwrite              <= 1'b0;
         hsize               <= '0;
         hprot               <= '0;
         hwdata              <= '0;
      end else begin
         freeahb_next  <= 1'b0;
         freeahb_ready <= 1'b0;
         freeahb_err   <= 1'b0;
         case (state)
            S_IDLE: begin
               if (freeahb_read || freeahb_write) begin
                  addr_q    <= freeahb_addr;
                  size_q    <= freeahb_size;
                  write_q   <= ~freeahb_read;
                  wdata_q   <= freeahb_wdata;
                  prot_q    <= freeahb_prot;
                  lock_q    <= freeahb_lock;
                  hlock     <= freeahb_lock;
                  hbusreq   <= 1'b1;
                  next_done <= 1'b0;
                  state     <= S_REQ;
               end
            end
            S_REQ: begin
               if (hgrant && hready) begin
                  htrans <= TRANS_NONSEQ;
                  haddr  <= addr_q;
                  hwrite <= write_q;
                  hsize  <= size_q;
                  hprot  <= prot_q;
                  state  <= S_ADDR;
               end
            end
            S_ADDR: begin
               if (hready && hgrant) begin
                  htrans    <= TRANS_IDLE;
                  hwdata    <= wdata_q;
                  freeahb_next <= ~next_done;
                  next_done <= 1'b1;
                  if (!lock_q) begin
                     hbusreq <= 1'b0;
                  end
                  state <= S_DATA;
               end
            end
            S_DATA: begin
               htrans <= TRANS_IDLE;
               if (hready) begin
                  if (hresp[1] && (retry_cnt < MAX_R)) begin
                     retry_cnt <= retry_cnt + 8'd1;
                     hbusreq   <= 1'b1;
                     state     <= S_REQ;
                  end else begin
                     freeahb_result_addr <= addr_q;
                     freeahb_err         <= hresp[1] | hresp[0];
                     if (write_q) begin
                        freeahb_next <= 1'b1;
                     end else begin
                        freeahb_ready <= 1'b1;
                        freeahb_rdata <= (hresp == 2'b00) ? hrdata : 32'h0;
                     end
                     hbusreq   <= 1'b0;
                     hlock     <= 1'b0;
                     retry_cnt <= '0;
                     state     <= S_RELEASE;
                  end
               end
            end
            S_RELEASE: begin
               if (!freeahb_read && !freeahb_write) begin
                  state <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
